// File: rtl/prio_code_pkg.sv
// Shared constants and FSM state type for the priority-position code decoder.
package prio_code_pkg;
   localparam logic [7:0] CODE_NONE = 8'hF0;
   localparam int         CODE_MAX  = 15;
   localparam int         WORD_W    = 16;
   localparam int         CNT_W     = 5;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      ACC     = 2'd1,
      DISCARD = 2'd2
   } state_t;
endpackage

// File: rtl/pos_to_onehot.sv
// Classifies an 8-bit position code and expands bit indices to a one-hot word.
module pos_to_onehot
   import prio_code_pkg::*;
(
   input  logic [7:0]        i_code,
   output logic [WORD_W-1:0] o_onehot,
   output logic [3:0]        o_index,
   output logic              o_is_index,
   output logic              o_is_none,
   output logic              o_is_illegal
);
   logic w_is_index;

   assign w_is_index   = (i_code <= 8'(CODE_MAX));
   assign o_is_index   = w_is_index;
   assign o_is_none    = (i_code == CODE_NONE);
   assign o_is_illegal = !w_is_index && (i_code != CODE_NONE);
   assign o_index      = i_code[3:0];
   assign o_onehot     = w_is_index ? (WORD_W'(1) << i_code[3:0]) : '0;
endmodule

// File: rtl/prio_code_decoder.sv
// Rebuilds a 16-bit word from a descending stream of set-bit position codes,
// emitting word and popcount on each 0xF0 terminator.
module prio_code_decoder
   import prio_code_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       code_in,
   input  logic             code_valid,
   output logic             code_ready,
   output logic [7:0]       word_a,
   output logic [7:0]       word_b,
   output logic [CNT_W-1:0] bit_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err,
   input  logic             err_clr
);
   state_t            r_state;
   logic [WORD_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [3:0]        r_last;
   logic [WORD_W-1:0] r_word;
   logic [CNT_W-1:0]  r_count;
   logic              r_out_valid;
   logic              r_err;

   logic [WORD_W-1:0] w_onehot;
   logic [3:0]        w_index;
   logic              w_is_index;
   logic              w_is_none;
   logic              w_is_illegal;
   logic              w_accept;
   logic              w_in_order;
   logic              w_err_evt;

   pos_to_onehot u_pos (
      .i_code       (code_in),
      .o_onehot     (w_onehot),
      .o_index      (w_index),
      .o_is_index   (w_is_index),
      .o_is_none    (w_is_none),
      .o_is_illegal (w_is_illegal)
   );

   // Codes stall whenever an undelivered word occupies the output register.
   assign code_ready = !r_out_valid || out_ready;
   assign w_accept   = code_valid && code_ready;
   assign w_in_order = w_is_index && (w_index < r_last);
   assign w_err_evt  = w_accept &&
                       (((r_state != DISCARD) && w_is_illegal) ||
                        ((r_state == ACC) && w_is_index && !w_in_order));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= EMPTY;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_last      <= '0;
         r_word      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (r_out_valid && out_ready)
            r_out_valid <= 1'b0;

         if (w_err_evt)
            r_err <= 1'b1;
         else if (err_clr)
            r_err <= 1'b0;

         // A terminator accepted here overrides the consume above.
         if (w_accept) begin
            case (r_state)
               EMPTY: begin
                  if (w_is_index) begin
                     r_acc   <= w_onehot;
                     r_cnt   <= CNT_W'(1);
                     r_last  <= w_index;
                     r_state <= ACC;
                  end else if (w_is_none) begin
                     r_word      <= '0;
                     r_count     <= '0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= DISCARD;
                  end
               end
               ACC: begin
                  if (w_in_order) begin
                     r_acc  <= r_acc | w_onehot;
                     r_cnt  <= r_cnt + CNT_W'(1);
                     r_last <= w_index;
                  end else if (w_is_none) begin
                     r_word      <= r_acc;
                     r_count     <= r_cnt;
                     r_out_valid <= 1'b1;
                     r_acc       <= '0;
                     r_cnt       <= '0;
                     r_state     <= EMPTY;
                  end else begin
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_state <= DISCARD;
                  end
               end
               DISCARD: begin
                  if (w_is_none)
                     r_state <= EMPTY;
               end
               default: r_state <= EMPTY;
            endcase
         end
      end
   end

   assign word_a    = r_word[15:8];
   assign word_b    = r_word[7:0];
   assign bit_count = r_count;
   assign out_valid = r_out_valid;
   assign err       = r_err;
endmodule

// File: tb/tb_prio_code_decoder.sv
// Bench for prio_code_decoder: directed scenarios plus a randomized word stream
// checked against a per-word legality/OR model.
module tb_prio_code_decoder;
   localparam logic [7:0] NONE = 8'hF0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] code_in = '0;
   logic       code_valid = 1'b0;
   logic       code_ready;
   logic [7:0] word_a;
   logic [7:0] word_b;
   logic [4:0] bit_count;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       err;
   logic       err_clr = 1'b0;

   int errors = 0;
   int checks = 0;
   bit rnd_bp = 1'b0;

   typedef struct packed {
      logic [15:0] w;
      logic [4:0]  c;
   } item_t;
   item_t got_q[$];
   item_t exp_q[$];

   prio_code_decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .word_a     (word_a),
      .word_b     (word_b),
      .bit_count  (bit_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err        (err),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   // Values here are exactly those the DUT samples on the following rising edge.
   always @(negedge clk)
      if (rst_n && out_valid && out_ready)
         got_q.push_back({word_a, word_b, bit_count});

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      bit ok;
      int n;
      ok = 1'b0;
      n = 0;
      code_in = c;
      code_valid = 1'b1;
      do begin
         if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         ok = code_ready;
         cyc();
         n++;
      end while (!ok && n < 200);
      code_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_accept: code %h got code_ready=0 after %0d cycles, need 1", c, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) cyc();
      checks++;
      if ({out_valid, word_a, word_b, bit_count, err} !== 23'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h need 0", {out_valid, word_a, word_b, bit_count, err});
      end
      rst_n = 1'b1;
      cyc();
      checks++;
      if (code_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b need 1", code_ready);
      end
   endtask

   task automatic test_basic();
      got_q.delete();
      out_ready = 1'b1;
      send(15); send(3); send(0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early_valid: got %b need 0", out_valid);
      end
      send(NONE);
      checks++;
      if ({out_valid, word_a, word_b, bit_count, err} !== {1'b1, 8'h80, 8'h09, 5'd3, 1'b0}) begin
         errors++;
         $display("FAIL basic_word: got %h need %h", {out_valid, word_a, word_b, bit_count, err},
                  {1'b1, 8'h80, 8'h09, 5'd3, 1'b0});
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0 || got_q.size() != 1) begin
         errors++;
         $display("FAIL basic_pulse: got valid=%b words=%0d need 0/1", out_valid, got_q.size());
      end
   endtask

   task automatic test_empty_full();
      send(NONE);
      checks++;
      if ({out_valid, word_a, word_b, bit_count} !== {1'b1, 8'h00, 8'h00, 5'd0}) begin
         errors++;
         $display("FAIL empty_word: got %h need %h", {out_valid, word_a, word_b, bit_count},
                  {1'b1, 8'h00, 8'h00, 5'd0});
      end
      for (int i = 15; i >= 0; i--) send(8'(i));
      send(NONE);
      checks++;
      if ({out_valid, word_a, word_b, bit_count, err} !== {1'b1, 8'hFF, 8'hFF, 5'd16, 1'b0}) begin
         errors++;
         $display("FAIL full_word: got %h need %h", {out_valid, word_a, word_b, bit_count, err},
                  {1'b1, 8'hFF, 8'hFF, 5'd16, 1'b0});
      end
      cyc();
   endtask

   task automatic test_order_err();
      got_q.delete();
      send(5); send(7);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL order_err_set: got %b need 1", err);
      end
      send(2); send(NONE);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL order_no_emit: got valid=%b need 0", out_valid);
      end
      cyc();
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL order_dropped: got %0d words need 0", got_q.size());
      end
      send(1); send(NONE);
      checks++;
      if ({out_valid, word_a, word_b, bit_count} !== {1'b1, 8'h00, 8'h02, 5'd1}) begin
         errors++;
         $display("FAIL order_recover: got %h need %h", {out_valid, word_a, word_b, bit_count},
                  {1'b1, 8'h00, 8'h02, 5'd1});
      end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clr: got %b need 0", err);
      end
      err_clr = 1'b1;
      send(8'h33);
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_clr_collide: got %b need 1", err);
      end
      send(NONE);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
   endtask

   task automatic test_illegal();
      got_q.delete();
      send(8'h20);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_err: got %b need 1", err);
      end
      send(4); send(NONE);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_no_emit: got valid=%b need 0", out_valid);
      end
      send(6); send(NONE);
      checks++;
      if ({out_valid, word_a, word_b, bit_count, err} !== {1'b1, 8'h00, 8'h40, 5'd1, 1'b1}) begin
         errors++;
         $display("FAIL illegal_next_word: got %h need %h", {out_valid, word_a, word_b, bit_count, err},
                  {1'b1, 8'h00, 8'h40, 5'd1, 1'b1});
      end
      cyc();
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {16'h0040, 5'd1}) begin
         errors++;
         $display("FAIL illegal_stream: got %0d words need 1 word 0040/1", got_q.size());
      end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
   endtask

   task automatic test_backpressure();
      got_q.delete();
      out_ready = 1'b0;
      send(8); send(NONE);
      code_in = NONE;
      code_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({code_ready, out_valid, word_a, word_b, bit_count} !== {1'b0, 1'b1, 8'h01, 8'h00, 5'd1}) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: got %h need %h", i,
                     {code_ready, out_valid, word_a, word_b, bit_count}, {1'b0, 1'b1, 8'h01, 8'h00, 5'd1});
         end
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      code_valid = 1'b0;
      checks++;
      if ({out_valid, word_a, word_b, bit_count} !== {1'b1, 8'h00, 8'h00, 5'd0}) begin
         errors++;
         $display("FAIL bp_reload: got %h need %h", {out_valid, word_a, word_b, bit_count},
                  {1'b1, 8'h00, 8'h00, 5'd0});
      end
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {16'h0100, 5'd1}) begin
         errors++;
         $display("FAIL bp_old_word: got %0d words need 1 word 0100/1", got_q.size());
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0 || got_q.size() != 2) begin
         errors++;
         $display("FAIL bp_drain: got valid=%b words=%0d need 0/2", out_valid, got_q.size());
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send(2); send(NONE);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, word_a, word_b, bit_count, err} !== 23'd0) begin
         errors++;
         $display("FAIL rst_pending: got %h need 0", {out_valid, word_a, word_b, bit_count, err});
      end
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b1;
      cyc();
      send(9); send(4);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, word_a, word_b, bit_count, err} !== 23'd0) begin
            errors++;
            $display("FAIL rst_mid cycle %0d: got %h need 0", i, {out_valid, word_a, word_b, bit_count, err});
         end
         cyc();
      end
      rst_n = 1'b1;
      got_q.delete();
      send(NONE);
      checks++;
      if ({out_valid, word_a, word_b, bit_count, err} !== {1'b1, 8'h00, 8'h00, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL rst_after_word: got %h need %h", {out_valid, word_a, word_b, bit_count, err},
                  {1'b1, 8'h00, 8'h00, 5'd0, 1'b0});
      end
      cyc();
   endtask

   task automatic test_random();
      logic [7:0]  codes[$];
      logic [15:0] mask;
      logic [15:0] w;
      logic [7:0]  bad;
      bit          legal;
      bit          err_exp;
      int          prev;
      int          n;
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      got_q.delete();
      exp_q.delete();
      err_exp = 1'b0;
      rnd_bp = 1'b1;
      for (int k = 0; k < 60; k++) begin
         codes.delete();
         mask = 16'($urandom);
         if ($urandom_range(0, 1) == 1) mask &= 16'($urandom);
         for (int b = 15; b >= 0; b--)
            if (mask[b]) codes.push_back(8'(b));
         if ($urandom_range(0, 3) == 0) begin
            bad = 8'($urandom_range(0, 255));
            if (bad == NONE) bad = 8'hEE;
            codes.insert($urandom_range(0, codes.size()), bad);
         end
         // A word is delivered only if every code is a bit index strictly below its predecessor.
         legal = 1'b1;
         prev = 16;
         w = '0;
         foreach (codes[j]) begin
            if (int'(codes[j]) > 15 || int'(codes[j]) >= prev) legal = 1'b0;
            else w = w | (16'd1 << codes[j][3:0]);
            prev = int'(codes[j]);
         end
         foreach (codes[j]) send(codes[j]);
         send(NONE);
         if (legal) exp_q.push_back({w, 5'(codes.size())});
         else err_exp = 1'b1;
      end
      rnd_bp = 1'b0;
      out_ready = 1'b1;
      repeat (3) cyc();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d words need %0d", got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_word %0d: got %h/%0d need %h/%0d", i, got_q[i].w, got_q[i].c,
                     exp_q[i].w, exp_q[i].c);
         end
      end
      checks++;
      if (err !== err_exp) begin
         errors++;
         $display("FAIL rand_err: got %b need %b", err, err_exp);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty_full();
      test_order_err();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prio_code_decoder.md
# prio_code_decoder

Sequential decoder for the 16-bit priority-position code format. It accepts a stream of 8-bit position codes (0–15, plus the all-zero marker 0xF0) over a valid/ready handshake. Codes for one word arrive in strictly descending order, and the block ORs each into a 16-bit word split into upper and lower bytes. On the 0xF0 terminator it emits the reconstructed word and its set-bit count through an output handshake. It sits downstream of the priority encoder path and lets a multi-bit word be rebuilt from successive "highest set bit" reports.

## Interface
- No parameters; widths fixed (8-bit code, 16-bit word, 5-bit count).
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- code_in  in  8  position code: 0–15 = bit index, 0xF0 = terminator/empty, others illegal
- code_valid  in  1  code_in valid
- code_ready  out  1  block accepts code this cycle
- word_a  out  8  reconstructed bits [15:8]
- word_b  out  8  reconstructed bits [7:0]
- bit_count  out  5  number of bits set in emitted word (0–16)
- out_valid  out  1  word_a/word_b/bit_count valid
- out_ready  in  1  consumer accepts word
- err  out  1  sticky error flag
- err_clr  in  1  synchronous clear of err

## Operation
- A code is accepted on an edge where code_valid && code_ready.
- code_ready = !out_valid || out_ready. This is combinational, and all codes stall while an undelivered word is held.
- FSM states:
  - EMPTY: accumulator zero, no previous index.
  - ACC: at least one bit accumulated, last index held in a 4-bit register.
  - DISCARD: dropping the rest of a bad word.
- EMPTY:
  - Code 0–15: set bit, count=1, record index, go to ACC.
  - 0xF0: emit 0x0000 with count 0, stay in EMPTY.
  - Illegal code: set err, go to DISCARD.
- ACC:
  - Code 0–15 below the last index: set bit, count+1, record index.
  - Code ≥ last index (duplicate or out of order): set err, clear accumulator, go to DISCARD.
  - 0xF0: emit accumulator and count, clear both, go to EMPTY.
  - Illegal code: set err, go to DISCARD.
- DISCARD:
  - All codes are consumed with no effect, except that 0xF0 returns to EMPTY with no word emitted.
- Emit:
  - Load output registers and set out_valid.
  - out_valid clears on the edge where out_valid && out_ready, unless a new terminator is accepted on the same edge. In that case the new word is loaded and out_valid stays 1.
- err:
  - Set on any error event.
  - Cleared by err_clr.
  - Error event and err_clr on the same edge: err = 1.
- Count width: 16 codes max per word (15…0), so count saturates naturally at 16 and never wraps.

## Timing
- Reset (async assert, sync release):
  - Outputs: word_a=0, word_b=0, bit_count=0, out_valid=0, err=0.
  - FSM: EMPTY, accumulator cleared.
  - code_ready=1 while rst_n high and out_valid=0.
- Latency: terminator accepted at edge N gives out_valid=1 and data valid immediately after edge N (1 cycle).
- Throughput: one code per cycle; back-to-back words with no bubble when out_ready=1.
- Output data is stable while out_valid && !out_ready.
- Reset mid-word or while out_valid=1 discards everything, with no partial emission.
- err asserts the cycle after the offending code is accepted.

## Structure
- Package prio_code_pkg:
  - CODE_NONE = 8'hF0.
  - CODE_MAX = 15.
  - Word width 16, count width 5.
  - FSM state typedef: EMPTY, ACC, DISCARD.
- Sub-module pos_to_onehot (combinational):
  - Input: code.
  - Outputs: 16-bit one-hot, is_index (code ≤ 15), is_none (code == 0xF0), is_illegal.
- The top level holds the FSM, accumulator, last-index register, counter, output register and err.

## Test plan
- Codes 15, 3, 0, 0xF0 with out_ready=1 → one out_valid pulse with word_a=0x80, word_b=0x09, bit_count=3, err=0.
- 0xF0 alone, then codes 15…0 followed by 0xF0 → first word 0x00/0x00 count 0; second word 0xFF/0xFF count 16.
- Codes 5, 7, 2, 0xF0 → err=1 after the 7 is accepted; no out_valid for that word; FSM back to EMPTY. Then err_clr=1 for one cycle → err=0.
- Code 0x20, then 4, 0xF0, then 6, 0xF0 → err=1 and the first word is dropped; second word word_a=0x00, word_b=0x40, count 1.
- Backpressure: word pending with out_ready=0 → code_ready=0 and data held stable for 5 cycles. Then out_ready=1 together with code 0xF0 on the same edge → old word consumed, new word (empty, 0x0000) loaded, out_valid stays 1.
- Codes 9, 4, then rst_n low for 2 cycles, then 0xF0 → all outputs 0 during reset; after release, word 0x0000 count 0 emitted.
